// File: rtl/bt_drive_sequencer.sv
// bt_drive_sequencer
//   Command controller between the Bluetooth UART receiver and the car
//   actuators. It validates and latches command bytes, moves between forward
//   and reverse only through a neutral settle interval, rate-limits laser
//   shots, and forces a safe stop on link loss or command timeout.
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   rx_byte    received command byte: [1:0] dir, [3:2] thr, [4] shoot, [7:5] 000
//   rx_valid   1-cycle strobe qualifying rx_byte
//   link_up    BT module STATUS pin (1 = paired)
//   throttle   00 stop, 01 forward, 10 reverse
//   direction  00 centre, 01 left, 10 right
//   fire_req   laser enable pulse
//   failsafe   1 while the drive FSM is in FAILSAFE
//   cmd_led    last accepted byte
//   err_cnt    rejected-byte count, saturating at 255
module bt_drive_sequencer #(
  parameter int unsigned TIMEOUT_CYC  = 50_000_000,
  parameter int unsigned SETTLE_CYC   = 10_000_000,
  parameter int unsigned FIRE_CYC     = 5_000_000,
  parameter int unsigned COOLDOWN_CYC = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  input  logic       link_up,
  output logic [1:0] throttle,
  output logic [1:0] direction,
  output logic       fire_req,
  output logic       failsafe,
  output logic [7:0] cmd_led,
  output logic [7:0] err_cnt
);

  localparam int unsigned LAS_MAX = (FIRE_CYC > COOLDOWN_CYC) ? FIRE_CYC : COOLDOWN_CYC;
  localparam int unsigned WD_W    = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned ST_W    = $clog2(SETTLE_CYC + 1);
  localparam int unsigned LC_W    = $clog2(LAS_MAX + 1);

  localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [ST_W-1:0] ST_LAST   = ST_W'(SETTLE_CYC - 1);
  localparam logic [LC_W-1:0] FIRE_LAST = LC_W'(FIRE_CYC - 1);
  localparam logic [LC_W-1:0] COOL_LAST = LC_W'(COOLDOWN_CYC - 1);

  typedef enum logic [1:0] {D_FAILSAFE, D_STOP, D_DRIVE, D_SETTLE} drv_e;
  typedef enum logic [1:0] {L_IDLE, L_FIRE, L_COOL} las_e;

  drv_e            drv_q, drv_d;
  las_e            las_q, las_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [ST_W-1:0] st_q, st_d;
  logic [LC_W-1:0] lc_q, lc_d;
  logic [1:0]      tgt_q, tgt_d;
  logic            prev_q, prev_d;
  logic [1:0]      thr_q, thr_d;
  logic [1:0]      dir_q, dir_d;
  logic            fire_q, fire_d;
  logic            fs_q, fs_d;
  logic [7:0]      led_q, led_d;
  logic [7:0]      err_q, err_d;

  logic       acc, rej, expire, force_fs, shot, b_shoot;
  logic [1:0] b_dir, b_thr;

  assign acc      = rx_valid & link_up & (rx_byte[7:5] == 3'b000);
  assign rej      = rx_valid & link_up & (rx_byte[7:5] != 3'b000);
  assign b_dir    = (rx_byte[1:0] == 2'b11) ? 2'b00 : rx_byte[1:0];
  assign b_thr    = (rx_byte[3:2] == 2'b11) ? 2'b00 : rx_byte[3:2];
  assign b_shoot  = rx_byte[4];
  // An accept on the expiry cycle clears the watchdog and so wins.
  assign expire   = ~acc & (wd_q == WD_LAST);
  assign force_fs = ~link_up | expire;
  // Rising edge of the shoot bit across accepted bytes, only while armed.
  assign shot     = acc & b_shoot & ~prev_q & (drv_q != D_FAILSAFE);

  always_ff @(posedge clk) begin
    if (rst) begin
      drv_q  <= D_FAILSAFE;
      las_q  <= L_IDLE;
      wd_q   <= '0;
      st_q   <= '0;
      lc_q   <= '0;
      tgt_q  <= '0;
      prev_q <= 1'b0;
      thr_q  <= '0;
      dir_q  <= '0;
      fire_q <= 1'b0;
      fs_q   <= 1'b1;
      led_q  <= '0;
      err_q  <= '0;
    end else begin
      drv_q  <= drv_d;
      las_q  <= las_d;
      wd_q   <= wd_d;
      st_q   <= st_d;
      lc_q   <= lc_d;
      tgt_q  <= tgt_d;
      prev_q <= prev_d;
      thr_q  <= thr_d;
      dir_q  <= dir_d;
      fire_q <= fire_d;
      fs_q   <= fs_d;
      led_q  <= led_d;
      err_q  <= err_d;
    end
  end

  // Next-state logic. tgt holds the running throttle in DRIVE and the
  // pending throttle in SETTLE, so SETTLE exits straight into DRIVE with it.
  always_comb begin
    drv_d  = drv_q;
    las_d  = las_q;
    st_d   = st_q;
    lc_d   = lc_q;
    tgt_d  = tgt_q;
    wd_d   = acc ? '0 : ((wd_q == WD_LAST) ? wd_q : wd_q + 1'b1);
    err_d  = (rej && (err_q != 8'hFF)) ? err_q + 1'b1 : err_q;
    led_d  = acc ? rx_byte : led_q;
    prev_d = (force_fs || (drv_q == D_FAILSAFE)) ? 1'b0 : (acc ? b_shoot : prev_q);

    if (force_fs) begin
      drv_d = D_FAILSAFE;
      las_d = L_IDLE;
      lc_d  = '0;
    end else begin
      unique case (drv_q)
        D_FAILSAFE: if (acc && (b_thr == 2'b00)) drv_d = D_STOP;
        D_STOP: if (acc && (b_thr != 2'b00)) begin
          drv_d = D_DRIVE;
          tgt_d = b_thr;
        end
        D_DRIVE: if (acc) begin
          if (b_thr == 2'b00) begin
            drv_d = D_STOP;
          end else if (b_thr != tgt_q) begin
            drv_d = D_SETTLE;
            tgt_d = b_thr;
            st_d  = '0;
          end
        end
        D_SETTLE: begin
          if (acc && (b_thr == 2'b00)) begin
            drv_d = D_STOP;
          end else begin
            if (acc) tgt_d = b_thr;
            if (st_q == ST_LAST) drv_d = D_DRIVE;
            else                 st_d  = st_q + 1'b1;
          end
        end
        default: drv_d = D_FAILSAFE;
      endcase

      unique case (las_q)
        L_IDLE: if (shot) begin
          las_d = L_FIRE;
          lc_d  = '0;
        end
        L_FIRE: begin
          if (lc_q == FIRE_LAST) begin
            las_d = L_COOL;
            lc_d  = '0;
          end else begin
            lc_d = lc_q + 1'b1;
          end
        end
        L_COOL: begin
          if (lc_q == COOL_LAST) las_d = L_IDLE;
          else                   lc_d  = lc_q + 1'b1;
        end
        default: las_d = L_IDLE;
      endcase
    end
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    thr_d  = (drv_d == D_DRIVE) ? tgt_d : 2'b00;
    dir_d  = (drv_d == D_FAILSAFE) ? 2'b00 : (acc ? b_dir : dir_q);
    fire_d = (las_d == L_FIRE);
    fs_d   = (drv_d == D_FAILSAFE);
  end

  assign throttle  = thr_q;
  assign direction = dir_q;
  assign fire_req  = fire_q;
  assign failsafe  = fs_q;
  assign cmd_led   = led_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_bt_drive_sequencer.sv
module tb_bt_drive_sequencer;

  localparam int TO  = 100;
  localparam int ST  = 8;
  localparam int FC  = 10;
  localparam int CC  = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       link_up;
  logic [1:0] throttle, direction;
  logic       fire_req, failsafe;
  logic [7:0] cmd_led, err_cnt;

  int checks = 0;
  int errors = 0;

  bt_drive_sequencer #(
    .TIMEOUT_CYC (TO),
    .SETTLE_CYC  (ST),
    .FIRE_CYC    (FC),
    .COOLDOWN_CYC(CC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .link_up  (link_up),
    .throttle (throttle),
    .direction(direction),
    .fire_req (fire_req),
    .failsafe (failsafe),
    .cmd_led  (cmd_led),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: timestamps of the last accept, settle entry and shot
  // stand in for the hardware counters.
  localparam int M_FS = 0, M_STOP = 1, M_DRIVE = 2, M_SETTLE = 3;
  int         m_e = 0;
  int         m_mode, m_last, m_settle_t, m_shot_t;
  logic [1:0] m_tgt, m_dir;
  logic       m_prev;
  logic [7:0] m_led, m_err;

  always @(posedge clk) begin
    logic       acc, rej, expire, sh;
    logic [1:0] bd, bt;
    m_e++;
    if (rst) begin
      m_mode = M_FS; m_tgt = 0; m_dir = 0; m_prev = 0; m_led = 0; m_err = 0;
      m_last = m_e; m_settle_t = 0; m_shot_t = -1000;
    end else begin
      acc = rx_valid && link_up && (rx_byte[7:5] == 0);
      rej = rx_valid && link_up && (rx_byte[7:5] != 0);
      bd  = (rx_byte[1:0] == 3) ? 2'd0 : rx_byte[1:0];
      bt  = (rx_byte[3:2] == 3) ? 2'd0 : rx_byte[3:2];
      sh  = rx_byte[4];
      if (rej && m_err < 255) m_err = m_err + 1;
      if (acc) m_led = rx_byte;
      expire = !acc && (m_e - m_last >= TO);
      if (acc) m_last = m_e;
      if (!link_up || expire) begin
        m_mode = M_FS; m_prev = 0; m_shot_t = -1000;
      end else begin
        if (acc && sh && !m_prev && m_mode != M_FS && (m_e - m_shot_t > FC + CC))
          m_shot_t = m_e;
        if (m_mode == M_FS) m_prev = 0;
        else if (acc)       m_prev = sh;
        case (m_mode)
          M_FS:   if (acc && bt == 0) m_mode = M_STOP;
          M_STOP: if (acc && bt != 0) begin m_mode = M_DRIVE; m_tgt = bt; end
          M_DRIVE: if (acc) begin
            if (bt == 0) m_mode = M_STOP;
            else if (bt != m_tgt) begin m_mode = M_SETTLE; m_tgt = bt; m_settle_t = m_e; end
          end
          default: begin
            if (acc && bt == 0) m_mode = M_STOP;
            else begin
              if (acc) m_tgt = bt;
              if (m_e - m_settle_t >= ST) m_mode = M_DRIVE;
            end
          end
        endcase
      end
      m_dir = (m_mode == M_FS) ? 2'd0 : (acc ? bd : m_dir);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic [21:0] mo;
    @(posedge clk);
    #1;
    mo = {(m_mode == M_DRIVE) ? m_tgt : 2'd0, m_dir,
          (m_e - m_shot_t < FC) ? 1'b1 : 1'b0, (m_mode == M_FS) ? 1'b1 : 1'b0,
          m_led, m_err};
    chk("model", {10'd0, throttle, direction, fire_req, failsafe, cmd_led, err_cnt}, {10'd0, mo});
  endtask

  task automatic send(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_thr"}, 32'(throttle), 0);
    chk({tag, "_dir"}, 32'(direction), 0);
    chk({tag, "_fire"}, 32'(fire_req), 0);
    chk({tag, "_fs"}, 32'(failsafe), 1);
    chk({tag, "_led"}, 32'(cmd_led), 0);
    chk({tag, "_err"}, 32'(err_cnt), 0);
  endtask

  initial begin
    rst = 1'b1; link_up = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00;
    tick(); tick();
    rst = 1'b0;
    chk_reset("reset");

    // Arming: throttle byte ignored in failsafe, thr=00 byte re-arms.
    send(8'h04);
    chk("t1_fs_hold", 32'(failsafe), 1);
    chk("t1_thr_hold", 32'(throttle), 0);
    send(8'h01);
    chk("t1_rearm", 32'(failsafe), 0);
    chk("t1_dir", 32'(direction), 1);
    send(8'h04);
    chk("t1_fwd", 32'(throttle), 1);

    // Forward -> reverse through 8 neutral cycles.
    send(8'h08);
    chk("t2_settle0", 32'(throttle), 0);
    for (int i = 1; i < ST; i++) begin
      tick();
      chk("t2_settle", 32'(throttle), 0);
    end
    tick();
    chk("t2_rev", 32'(throttle), 2);
    send(8'h04);
    tick(); tick(); tick();
    send(8'h00);
    for (int i = 0; i < 10; i++) begin
      chk("t2_stop", 32'(throttle), 0);
      tick();
    end

    // Laser pulse, dropped shots during cooldown, new pulse afterwards.
    send(8'h10);
    for (int i = 0; i < FC; i++) begin
      chk("t3_pulse", 32'(fire_req), 1);
      if (i < FC - 1) tick();
    end
    tick();
    chk("t3_pulse_end", 32'(fire_req), 0);
    send(8'h00);
    send(8'h10);
    for (int i = 0; i < 23; i++) begin
      chk("t3_cool_drop", 32'(fire_req), 0);
      tick();
    end
    send(8'h00);
    send(8'h10);
    chk("t3_second", 32'(fire_req), 1);
    for (int i = 0; i < 40; i++) tick();
    chk("t3_second_end", 32'(fire_req), 0);

    // Watchdog expiry and accept exactly on the expiry cycle.
    send(8'h00);
    for (int i = 0; i < TO - 1; i++) tick();
    chk("t4_pre_expiry", 32'(failsafe), 0);
    tick();
    chk("t4_expired", 32'(failsafe), 1);
    chk("t4_thrdir", 32'({throttle, direction}), 0);
    send(8'h01);
    send(8'h04);
    for (int i = 0; i < TO - 1; i++) tick();
    chk("t4_pre_expiry2", 32'(failsafe), 0);
    send(8'h04);
    chk("t4_accept_wins", 32'(failsafe), 0);
    chk("t4_thr_kept", 32'(throttle), 1);

    // Link loss mid-shot while driving.
    send(8'h14);
    chk("t5_shot", 32'(fire_req), 1);
    tick(); tick(); tick();
    link_up = 1'b0;
    tick();
    chk("t5_fs", 32'(failsafe), 1);
    chk("t5_fire", 32'(fire_req), 0);
    chk("t5_thr", 32'(throttle), 0);
    link_up = 1'b1;
    send(8'h00);

    // Rejected bytes and saturation.
    send(8'h80);
    send(8'hE4);
    chk("t6_err2", 32'(err_cnt), 2);
    chk("t6_led", 32'(cmd_led), 0);
    chk("t6_fs", 32'(failsafe), 0);
    for (int i = 0; i < 300; i++) send(8'(($urandom_range(1, 7) << 5) | $urandom_range(0, 31)));
    chk("t6_sat", 32'(err_cnt), 255);

    // Reset mid-settle and mid-shot.
    send(8'h00);
    send(8'h04);
    send(8'h18);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset("midrst");
    send(8'h04);
    chk("midrst_rearm_req", 32'(failsafe), 1);

    // Randomised traffic against the model.
    for (int i = 0; i < 2500; i++) begin
      rst     = ($urandom_range(0, 999) == 0);
      link_up = ($urandom_range(0, 199) != 0);
      if ((i % 600) > 480) begin
        rx_valid = 1'b0;
      end else begin
        rx_valid = ($urandom_range(0, 3) == 0);
        rx_byte  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31));
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
